// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   size_e  : access size encoding carried on req_size
//   state_e : responder FSM states
//   CNT_W   : width of the wait-state counter (LATENCY is at most 15)
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one memory word.
// Ports:
//   size          in   access size (size_e encoding)
//   addr_lo       in   byte lane within the word (addr[1:0])
//   is_unsigned   in   loads: 1 = zero-extend, 0 = sign-extend
//   wdata         in   right-aligned store data
//   rdata_raw     in   current contents of the addressed word
//   byte_en       out  lanes touched by the access
//   wdata_merged  out  rdata_raw with the enabled lanes replaced by store data
//   load_data     out  selected lane(s) extended to 32 bits
//   misalign      out  half on an odd address or word not on a word boundary
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_merged,
  output logic [31:0] load_data,
  output logic        misalign
);

  function automatic logic [31:0] extend_byte(input logic [7:0] v, input logic zext);
    logic signed [7:0]  sv;
    logic signed [31:0] ext;
    sv  = signed'(v);
    ext = sv;
    return zext ? {24'd0, v} : ext;
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] v, input logic zext);
    logic signed [15:0] sv;
    logic signed [31:0] ext;
    sv  = signed'(v);
    ext = sv;
    return zext ? {16'd0, v} : ext;
  endfunction

  logic [31:0] lanes;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata_raw[8*addr_lo +: 8];
    sel_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
  end

  always_comb begin
    byte_en   = '0;
    lanes     = '0;
    load_data = '0;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        lanes     = {4{wdata[7:0]}};
        load_data = extend_byte(sel_byte, is_unsigned);
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lanes     = {2{wdata[15:0]}};
        load_data = extend_half(sel_half, is_unsigned);
        misalign  = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en   = 4'b1111;
        lanes     = wdata;
        load_data = rdata_raw;
        misalign  = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    wdata_merged = rdata_raw;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wdata_merged[8*i +: 8] = lanes[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory slave with programmable wait states.
// One request is accepted at a time, held for LATENCY cycles, performed on an
// internal word array in a single ACCESS cycle, and answered over rsp_*.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write, req_addr, req_size, req_unsigned, req_wdata   request fields
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_error  load result (0 for stores/errors), illegal-request flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic             write_p0;
  logic [31:0]      addr_p0;
  logic [1:0]       size_p0;
  logic             unsigned_p0;
  logic [31:0]      wdata_p0;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [AW-1:0]    idx;
  logic             out_of_range;
  logic [31:0]      rd_word;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_merged;
  logic [31:0]      load_data;
  logic             misalign;
  logic             access_err;
  logic             wr_en;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // ---- request capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0    <= req_write;
      addr_p0     <= req_addr;
      size_p0     <= req_size;
      unsigned_p0 <= req_unsigned;
      wdata_p0    <= req_wdata;
    end
  end

  // ---- access stage: decode captured request against storage ----
  assign idx          = addr_p0[AW+1:2];
  assign out_of_range = |addr_p0[31:AW+2];
  assign rd_word      = mem[idx];

  dmem_lane_align u_lane_align (
    .size         (size_p0),
    .addr_lo      (addr_p0[1:0]),
    .is_unsigned  (unsigned_p0),
    .wdata        (wdata_p0),
    .rdata_raw    (rd_word),
    .byte_en      (byte_en),
    .wdata_merged (wdata_merged),
    .load_data    (load_data),
    .misalign     (misalign)
  );

  assign access_err = misalign || (size_p0 == SZ_RSVD) || out_of_range;
  // An async reset forces state away from ACCESS, so an aborted store never commits.
  assign wr_en      = (state == ACCESS) && write_p0 && !access_err;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && byte_en[i]) mem[idx][8*i +: 8] <= wdata_merged[8*i +: 8];
    end
  end

  // ---- control FSM and registered response ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready stays low through reset and rises on the first edge after it.
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ACCESS;
        end
        ACCESS: begin
          rsp_rdata <= (access_err || write_p0) ? '0 : load_data;
          rsp_error <= access_err;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed reference storage.
  logic [7:0] ref_mem [DEPTH*4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } op_t;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_error(b_rsp_error)
  );

  // Reference behaviour: byte-granular memory, natural alignment, range limit.
  task automatic model(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((addr % n) != 0) || (addr >= DEPTH*4);
    rd = '0;
    if (!er) begin
      if (wr) begin
        for (int k = 0; k < n; k++) ref_mem[addr+k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[addr+k];
        if (!uns && n < 4 && v[8*n-1])
          for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  // One transaction on the LATENCY=2 instance, entered and left #1 after a rising edge.
  // lat = edges from the acceptance edge to the one after which rsp_valid is seen
  // (-1: no response, -2: never accepted).
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                      input bit uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int guard;
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    rd = 'x;
    er = 'x;
    if (!req_ready) begin
      req_valid = 1'b0;
      lat = -2;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      lat = -1;
      return;
    end
    rd = rsp_rdata;
    er = rsp_error;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%0b want=0", rsp_error); end
    checks++; if (b_req_ready !== 1'b0) begin failures++; $display("FAIL reset_b_req_ready got=%0b want=0", b_req_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%0b want=1", req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_b_req_ready got=%0b want=1", b_req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_rsp_valid got=%0b want=0", rsp_valid); end
  endtask

  task automatic test_directed();
    op_t tbl[18];
    logic [31:0] rd;
    logic er;
    int lat;
    tbl[0]  = '{1'b1, 32'h10,  2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  2'd2, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h13,  2'd0, 1'b0, 32'hABCDEF80, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'h80000000, 1'b0};
    tbl[5]  = '{1'b0, 32'h13,  2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[6]  = '{1'b0, 32'h13,  2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0};
    tbl[7]  = '{1'b0, 32'h11,  2'd1, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b1, 32'h0,   2'd2, 1'b0, 32'h13579BDF, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 32'h400, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h0,   2'd2, 1'b0, 32'h0,        32'h13579BDF, 1'b0};
    tbl[11] = '{1'b0, 32'h12,  2'd2, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h10,  2'd3, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[13] = '{1'b0, 32'h12,  2'd1, 1'b0, 32'h0,        32'hFFFF8000, 1'b0};
    tbl[14] = '{1'b0, 32'h12,  2'd1, 1'b1, 32'h0,        32'h00008000, 1'b0};
    tbl[15] = '{1'b1, 32'h10,  2'd3, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        32'h80000000, 1'b0};
    tbl[17] = '{1'b0, 32'h10,  2'd2, 1'b1, 32'h0,        32'h80000000, 1'b0};
    for (int i = 0; i < 18; i++) begin
      xact(tbl[i].wr, tbl[i].addr, tbl[i].sz, tbl[i].uns, tbl[i].wd, rd, er, lat);
      checks++;
      if (rd !== tbl[i].exp_rd) begin failures++; $display("FAIL directed_rdata[%0d] got=%h want=%h", i, rd, tbl[i].exp_rd); end
      checks++;
      if (er !== tbl[i].exp_err) begin failures++; $display("FAIL directed_error[%0d] got=%b want=%0b", i, er, tbl[i].exp_err); end
      // LATENCY+2 edges counting the acceptance edge itself.
      checks++;
      if (lat != LAT + 1) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, LAT + 1); end
    end
  endtask

  task automatic test_stall();
    int guard;
    bit bad_hold;
    bit extra_rsp;
    rsp_ready    = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_addr = 32'h10;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_rsp_arrives got=%0b want=1", rsp_valid); end
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = ~req_valid;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h13579BDF || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        bad_hold = 1'b1;
        $display("FAIL stall_hold[%0d] got valid=%0b rdata=%h err=%0b req_ready=%0b want 1/13579bdf/0/0",
                 i, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got valid=%0b req_ready=%0b want 0/1", rsp_valid, req_ready);
    end
    extra_rsp = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) extra_rsp = 1'b1;
    end
    checks++;
    if (extra_rsp) begin failures++; $display("FAIL stall_no_second_accept got=1 want=0"); end
    if (bad_hold) $display("note: stall hold errors above");
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic er;
    int lat;
    int guard;
    bit seen;
    xact(1'b1, 32'h20, 2'd2, 1'b0, 32'hAAAAAAAA, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL abort_prestore_error got=%b want=0", er); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h12345678;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_reset got req_ready=%0b rsp_valid=%0b want 0/0", req_ready, rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL abort_no_response got=1 want=0"); end
    xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hAAAAAAAA || er !== 1'b0) begin
      failures++;
      $display("FAIL abort_store_dropped got=%h err=%b want=aaaaaaaa err=0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd;
    logic er, exp_er;
    logic [1:0] sz;
    bit wr, uns;
    int lat;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      xact(1'b1, 32'(w * 4), 2'd2, 1'b0, wd, rd, er, lat);
      model(1'b1, 32'(w * 4), 2'd2, 1'b0, wd, exp_rd, exp_er);
      checks++;
      if (er !== exp_er || rd !== exp_rd) begin
        failures++;
        $display("FAIL random_init[%0d] got=%h/%b want=%h/%b", w, rd, er, exp_rd, exp_er);
      end
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) addr = 32'(DEPTH * 4 + $urandom_range(0, 63));
      else                           addr = 32'($urandom_range(0, 63));
      sz  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      xact(wr, addr, sz, uns, wd, rd, er, lat);
      model(wr, addr, sz, uns, wd, exp_rd, exp_er);
      checks++;
      if (rd !== exp_rd) begin
        failures++;
        $display("FAIL random_rdata[%0d] wr=%0b addr=%h sz=%0d uns=%0b got=%h want=%h", i, wr, addr, sz, uns, rd, exp_rd);
      end
      checks++;
      if (er !== exp_er) begin
        failures++;
        $display("FAIL random_error[%0d] addr=%h sz=%0d got=%b want=%b", i, addr, sz, er, exp_er);
      end
      checks++;
      if (lat != LAT + 1) begin failures++; $display("FAIL random_latency[%0d] got=%0d want=%0d", i, lat, LAT + 1); end
    end
  endtask

  task automatic test_back_to_back();
    op_t tbl[7];
    int guard;
    int acc, prev;
    tbl[0] = '{1'b1, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 32'h6, 2'd1, 1'b0, 32'h1234BEEF, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 32'h9, 2'd0, 1'b0, 32'h5555557F, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 32'h0, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[4] = '{1'b0, 32'h6, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[5] = '{1'b0, 32'h9, 2'd0, 1'b0, 32'h0,        32'h0000007F, 1'b0};
    tbl[6] = '{1'b0, 32'h1, 2'd0, 1'b1, 32'h0,        32'h000000F0, 1'b0};
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      b_req_write    = tbl[i].wr;
      b_req_addr     = tbl[i].addr;
      b_req_size     = tbl[i].sz;
      b_req_unsigned = tbl[i].uns;
      b_req_wdata    = tbl[i].wd;
      guard = 0;
      while (!b_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) begin
        checks++;
        if (acc - prev != 3) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d want=3", i, acc - prev); end
      end
      prev = acc;
      guard = 0;
      while (!b_rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== tbl[i].exp_rd || b_rsp_error !== tbl[i].exp_err) begin
        failures++;
        $display("FAIL b2b_rsp[%0d] got valid=%0b rdata=%h err=%0b want 1/%h/%0b",
                 i, b_rsp_valid, b_rsp_rdata, b_rsp_error, tbl[i].exp_rd, tbl[i].exp_err);
      end
    end
    b_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_size = '0;
    b_req_unsigned = 1'b0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
